carregador_programa: RTL

Program loader for the instruction memory: the write-side counterpart of the program-counter/instruction-memory fetch path. Accepts a framed byte stream over a valid/ready handshake (length byte, N instruction bytes, XOR checksum), writes the bytes to consecutive instruction-memory addresses starting at 0, and reports completion and checksum status. It sits between the host/stimulus interface and the write port of the instruction memory, and holds the processor off while a program is being loaded.

---
 rtl/carregador_pkg.sv | 15 +
 rtl/contador_enderecos.sv | 24 ++
 rtl/carregador_programa.sv | 109 ++++++++++
 3 files changed

// File: rtl/carregador_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package carregador_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    // A length byte of zero encodes a full 2**ADDR_W-byte program.
    localparam bit LEN_ZERO_MEANS_256 = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        FIN  = 3'd4
    } state_t;
endpackage

// File: rtl/contador_enderecos.sv
// Clearable, enabled up-counter for the write address, with terminal-count
// flag that is high while the counter points at the last byte of the frame.
module contador_enderecos #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] n,
    output logic [W-1:0] count,
    output logic         tc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

    assign tc = (count == n - W'(1));
endmodule

// File: rtl/carregador_programa.sv
// Program loader: framed byte stream (length, data, XOR checksum) written to
// instruction memory from address 0, holding the processor off via busy.
module carregador_programa
    import carregador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic [ADDR_W:0]   count
);
    localparam int CW = ADDR_W + 1;

    state_t            state;
    logic [CW-1:0]     n_len;
    logic [CW-1:0]     len_n;
    logic [DATA_W-1:0] xsum;
    logic              accept;
    logic              cnt_clr;
    logic              cnt_en;
    logic              tc;

    assign accept  = in_valid && in_ready;
    assign cnt_clr = (state == IDLE) && start;
    assign cnt_en  = accept && (state == DATA);
    assign len_n   = (in_data == '0 && LEN_ZERO_MEANS_256) ? CW'(2 ** ADDR_W) : CW'(in_data);

    contador_enderecos #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .n     (n_len),
        .count (count),
        .tc    (tc)
    );

    // in_ready/busy/done are loaded alongside the state so they depend on state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            chk_err  <= 1'b0;
            n_len    <= '0;
            xsum     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LEN;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    chk_err  <= 1'b0;
                    xsum     <= '0;
                end
                LEN: if (accept) begin
                    n_len <= len_n;
                    state <= DATA;
                end
                DATA: if (accept) begin
                    xsum <= xsum ^ in_data;
                    if (tc) state <= CHK;
                end
                CHK: if (accept) begin
                    chk_err  <= (in_data != xsum);
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // mem_addr trails count by one cycle: it shows the written address during
    // the write, then the next free address (0 after a full 256-byte frame).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we   <= cnt_en;
            mem_addr <= count[ADDR_W-1:0];
            if (cnt_en) mem_wdata <= in_data;
        end
    end
endmodule
